// File: rtl/alu_pkg.sv
// alu_pkg: unit/function codes, FSM encoding and the unit-enable decoder shared by the ALU arbiter
package alu_pkg;
  localparam int FUNC_W = 4;
  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;
  localparam logic [1:0] LOGIC_AND  = 2'b00;
  localparam logic [1:0] LOGIC_OR   = 2'b01;
  localparam logic [1:0] LOGIC_NAND = 2'b10;
  localparam logic [1:0] LOGIC_NOR  = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  function automatic logic [3:0] unit_onehot(input logic [1:0] unit);
    return 4'b0001 << unit;
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input arbiter; ALU_ARB_RR_EN builds a round-robin pointer, otherwise req 0 always wins ties
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);
`ifdef ALU_ARB_RR_EN
  logic ptr_q;
  always_ff @(posedge clk) begin
    ptr_q <= rst ? 1'b0 : (upd_i ? ~gnt_id_o : ptr_q);
  end
  assign gnt_id_o = req_i[1] && (ptr_q || !req_i[0]);
`else
  logic unused;
  assign unused   = ^{clk, rst, upd_i};
  assign gnt_id_o = req_i[1] && !req_i[0];
`endif
  assign gnt_o = {gnt_id_o, req_i[0] && !gnt_id_o};
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one multi-unit ALU between two requesters and returns a tagged response
// ALU_ARB_RR_EN selects round-robin tie-breaking in rr_arb2 (fixed req0 priority otherwise)
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [FUNC_W-1:0] req0_func,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [FUNC_W-1:0] req1_func,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [WIDTH-1:0]  resp_data,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [1:0]        alu_func,
  output logic              arith_en,
  output logic              logic_en,
  output logic              cmp_en,
  output logic              shift_en,
  input  logic [WIDTH-1:0]  alu_out
);
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  if (ALU_LAT < 1) begin : g_bad_lat
    $error("alu_arbiter: ALU_LAT must be at least 1");
  end
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  a_q, b_q, data_q;
  logic [1:0]        func_q;
  logic [3:0]        en_q;
  logic              id_q, rid_q, rvalid_q;
  logic [1:0]        gnt;
  logic              gnt_id, accept;
  logic [FUNC_W-1:0] sel_func;
  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   ({req1_valid, req0_valid}),
    .upd_i   (accept),
    .gnt_o   (gnt),
    .gnt_id_o(gnt_id)
  );
  always_ff @(posedge clk) begin
    state_q <= rst ? S_IDLE : state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = accept ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = (cnt_q == '0) ? S_RESP : S_WAIT;
      S_RESP:  state_d = resp_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    req0_ready = !rst && state_q == S_IDLE && gnt[0];
    req1_ready = !rst && state_q == S_IDLE && gnt[1];
    accept     = req0_ready || req1_ready;
    sel_func   = gnt_id ? req1_func : req0_func;
  end
  // Operands and the unit enable are registered at acceptance so they are live during ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      func_q   <= '0;
      en_q     <= '0;
      id_q     <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
      rid_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      en_q <= '0;
      if (accept) begin
        a_q    <= gnt_id ? req1_a : req0_a;
        b_q    <= gnt_id ? req1_b : req0_b;
        func_q <= sel_func[1:0];
        en_q   <= unit_onehot(sel_func[3:2]);
        id_q   <= gnt_id;
      end
      if (state_q == S_ISSUE) cnt_q <= CW'(ALU_LAT - 1);
      if (state_q == S_WAIT && cnt_q != '0) cnt_q <= cnt_q - CW'(1);
      if (state_q == S_WAIT && cnt_q == '0) begin
        data_q   <= alu_out;
        rid_q    <= id_q;
        rvalid_q <= 1'b1;
      end
      if (state_q == S_RESP && resp_ready) rvalid_q <= 1'b0;
    end
  end
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_func   = func_q;
  assign arith_en   = en_q[UNIT_ARITH];
  assign logic_en   = en_q[UNIT_LOGIC];
  assign cmp_en     = en_q[UNIT_CMP];
  assign shift_en   = en_q[UNIT_SHIFT];
  assign resp_valid = rvalid_q;
  assign resp_id    = rid_q;
  assign resp_data  = data_q;
endmodule
